fmdownsample_axi: RTL and testbench



---
 rtl/fmdownsample_pkg.sv | 38 +++
 rtl/fmdownsample_axilite.sv | 158 +++++++++++++++
 rtl/fmdownsample_axi.sv | 184 ++++++++++++++++++
 tb/tb_fmdownsample_axi.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmdownsample_pkg.sv
// Shared definitions for the strided feature-map downsampler: register map,
// configuration bundle, AXI-Lite FSM states and the stream width helper.
package fmdownsample_pkg;

    // AXI-Lite word addresses of the configuration registers
    localparam logic [2:0] ADDR_XEND    = 3'd0;
    localparam logic [2:0] ADDR_XSTRIDE = 3'd1;
    localparam logic [2:0] ADDR_YEND    = 3'd4;
    localparam logic [2:0] ADDR_YSTRIDE = 3'd5;

    // Configuration fields are carried at a fixed width; counter widths up to
    // CFG_W bits are supported and the consumer slices off what it needs.
    localparam int CFG_W = 16;

    typedef struct packed {
        logic [CFG_W-1:0] xend;
        logic [CFG_W-1:0] xstride_m1;
        logic [CFG_W-1:0] yend;
        logic [CFG_W-1:0] ystride_m1;
    } cfg_t;

    typedef enum logic [1:0] {
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_ADDR,
        RD_DATA
    } rd_state_t;

    // Stream beat width: SIMD elements rounded up to whole bytes
    function automatic int stream_bits(input int simd, input int elem_bits);
        return 8 * (1 + (simd * elem_bits - 1) / 8);
    endfunction

endpackage

// File: rtl/fmdownsample_axilite.sv
// AXI-Lite slave holding the staging copy of the downsampler geometry.
// One write and one read may be outstanding at a time; handshake outputs
// are registered.
module fmdownsample_axilite
    import fmdownsample_pkg::*;
#(
    parameter int XCOUNTER_BITS    = 8,
    parameter int YCOUNTER_BITS    = 8,
    parameter int INIT_XEND        = 0,
    parameter int INIT_YEND        = 0,
    parameter int INIT_XSTRIDE_M1  = 0,
    parameter int INIT_YSTRIDE_M1  = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [2:0]  awaddr_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [31:0] wdata_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    input  logic [2:0]  araddr_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output cfg_t        cfg_o
);

    wr_state_t                wr_state_q;
    rd_state_t                rd_state_q;
    logic [2:0]               waddr_q;
    logic                     awready_q;
    logic                     wready_q;
    logic                     bvalid_q;
    logic                     arready_q;
    logic                     rvalid_q;
    logic [31:0]              rdata_q;
    logic [31:0]              rd_word;
    logic [XCOUNTER_BITS-1:0] xend_q;
    logic [XCOUNTER_BITS-1:0] xstride_q;
    logic [YCOUNTER_BITS-1:0] yend_q;
    logic [YCOUNTER_BITS-1:0] ystride_q;

    // Only the low counter-width bits of a write are stored
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    // Write channel: AW, then W (register update), then B; staging regs live here
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= WR_ADDR;
            waddr_q    <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            xend_q     <= XCOUNTER_BITS'(INIT_XEND);
            xstride_q  <= XCOUNTER_BITS'(INIT_XSTRIDE_M1);
            yend_q     <= YCOUNTER_BITS'(INIT_YEND);
            ystride_q  <= YCOUNTER_BITS'(INIT_YSTRIDE_M1);
        end else begin
            case (wr_state_q)
                WR_ADDR: begin
                    if (awvalid_i) begin
                        waddr_q    <= awaddr_i;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (wvalid_i) begin
                        case (waddr_q)
                            ADDR_XEND:    xend_q    <= wdata_i[XCOUNTER_BITS-1:0];
                            ADDR_XSTRIDE: xstride_q <= wdata_i[XCOUNTER_BITS-1:0];
                            ADDR_YEND:    yend_q    <= wdata_i[YCOUNTER_BITS-1:0];
                            ADDR_YSTRIDE: ystride_q <= wdata_i[YCOUNTER_BITS-1:0];
                            default:      ;
                        endcase
                        wready_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        wr_state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bready_i) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= WR_ADDR;
                    end
                end
                default: begin
                    wr_state_q <= WR_ADDR;
                    awready_q  <= 1'b1;
                    wready_q   <= 1'b0;
                    bvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    // Readback mux, zero-extended; unmapped addresses read as zero
    always_comb begin
        rd_word = '0;
        case (araddr_i)
            ADDR_XEND:    rd_word = 32'(xend_q);
            ADDR_XSTRIDE: rd_word = 32'(xstride_q);
            ADDR_YEND:    rd_word = 32'(yend_q);
            ADDR_YSTRIDE: rd_word = 32'(ystride_q);
            default:      rd_word = '0;
        endcase
    end

    // Read channel: AR captures data, R held until RREADY, ARREADY closed meanwhile
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= RD_ADDR;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_ADDR: begin
                    if (arvalid_i) begin
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= rd_word;
                        rd_state_q <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rready_i) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RD_ADDR;
                    end
                end
                default: rd_state_q <= RD_ADDR;
            endcase
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;

    assign cfg_o.xend       = CFG_W'(xend_q);
    assign cfg_o.xstride_m1 = CFG_W'(xstride_q);
    assign cfg_o.yend       = CFG_W'(yend_q);
    assign cfg_o.ystride_m1 = CFG_W'(ystride_q);

endmodule

// File: rtl/fmdownsample_axi.sv
// Strided feature-map downsampler: forwards only pixels whose x and y phase
// are both zero, with geometry and strides programmed over AXI-Lite.
// NUM_CHANNELS must be a multiple of SIMD.
module fmdownsample_axi
    import fmdownsample_pkg::*;
#(
    parameter int XCOUNTER_BITS   = 8,
    parameter int YCOUNTER_BITS   = 8,
    parameter int NUM_CHANNELS    = 4,
    parameter int SIMD            = 2,
    parameter int ELEM_BITS       = 4,
    parameter int INIT_XEND       = 0,
    parameter int INIT_YEND       = 0,
    parameter int INIT_XSTRIDE_M1 = 0,
    parameter int INIT_YSTRIDE_M1 = 0,
    localparam int STREAM_BITS    = stream_bits(SIMD, ELEM_BITS)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   s_axilite_AWVALID,
    output logic                   s_axilite_AWREADY,
    input  logic [2:0]             s_axilite_AWADDR,
    input  logic                   s_axilite_WVALID,
    output logic                   s_axilite_WREADY,
    input  logic [31:0]            s_axilite_WDATA,
    input  logic [3:0]             s_axilite_WSTRB,
    output logic                   s_axilite_BVALID,
    input  logic                   s_axilite_BREADY,
    output logic [1:0]             s_axilite_BRESP,
    input  logic                   s_axilite_ARVALID,
    output logic                   s_axilite_ARREADY,
    input  logic [2:0]             s_axilite_ARADDR,
    output logic                   s_axilite_RVALID,
    input  logic                   s_axilite_RREADY,
    output logic [31:0]            s_axilite_RDATA,
    output logic [1:0]             s_axilite_RRESP,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [STREAM_BITS-1:0] s_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [STREAM_BITS-1:0] m_axis_tdata
);

    localparam int BEATS  = NUM_CHANNELS / SIMD;
    localparam int S_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    cfg_t stage_cfg;

    logic [XCOUNTER_BITS-1:0] xend_q, xstride_q;
    logic [YCOUNTER_BITS-1:0] yend_q, ystride_q;
    logic [S_BITS-1:0]        s_q, s_d;
    logic [XCOUNTER_BITS-1:0] x_q, x_d, xph_q, xph_d;
    logic [YCOUNTER_BITS-1:0] y_q, y_d, yph_q, yph_d;
    logic                     tvalid_q;
    logic [STREAM_BITS-1:0]   tdata_q;
    logic                     keep;
    logic                     in_xfer;
    logic                     cfg_load;

    // Full-word writes only; upper staging bits beyond the counter widths are zero
    logic unused_inputs;
    assign unused_inputs = ^{s_axilite_WSTRB, stage_cfg};

    fmdownsample_axilite #(
        .XCOUNTER_BITS   (XCOUNTER_BITS),
        .YCOUNTER_BITS   (YCOUNTER_BITS),
        .INIT_XEND       (INIT_XEND),
        .INIT_YEND       (INIT_YEND),
        .INIT_XSTRIDE_M1 (INIT_XSTRIDE_M1),
        .INIT_YSTRIDE_M1 (INIT_YSTRIDE_M1)
    ) u_axilite (
        .clk_i     (ap_clk),
        .rst_i     (ap_rst),
        .awvalid_i (s_axilite_AWVALID),
        .awready_o (s_axilite_AWREADY),
        .awaddr_i  (s_axilite_AWADDR),
        .wvalid_i  (s_axilite_WVALID),
        .wready_o  (s_axilite_WREADY),
        .wdata_i   (s_axilite_WDATA),
        .bvalid_o  (s_axilite_BVALID),
        .bready_i  (s_axilite_BREADY),
        .arvalid_i (s_axilite_ARVALID),
        .arready_o (s_axilite_ARREADY),
        .araddr_i  (s_axilite_ARADDR),
        .rvalid_o  (s_axilite_RVALID),
        .rready_i  (s_axilite_RREADY),
        .rdata_o   (s_axilite_RDATA),
        .cfg_o     (stage_cfg)
    );

    assign s_axilite_BRESP = 2'b00;
    assign s_axilite_RRESP = 2'b00;

    assign keep          = (xph_q == '0) && (yph_q == '0);
    assign s_axis_tready = !keep || !tvalid_q || m_axis_tready;
    assign in_xfer       = s_axis_tvalid && s_axis_tready;
    // Config only changes between images, on an idle cycle at pixel (0,0)
    assign cfg_load      = (s_q == '0) && (x_q == '0) && (y_q == '0) && !in_xfer;

    // Active geometry: shadow of the staging registers, updated at image boundaries
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            xend_q    <= XCOUNTER_BITS'(INIT_XEND);
            xstride_q <= XCOUNTER_BITS'(INIT_XSTRIDE_M1);
            yend_q    <= YCOUNTER_BITS'(INIT_YEND);
            ystride_q <= YCOUNTER_BITS'(INIT_YSTRIDE_M1);
        end else if (cfg_load) begin
            xend_q    <= stage_cfg.xend[XCOUNTER_BITS-1:0];
            xstride_q <= stage_cfg.xstride_m1[XCOUNTER_BITS-1:0];
            yend_q    <= stage_cfg.yend[YCOUNTER_BITS-1:0];
            ystride_q <= stage_cfg.ystride_m1[YCOUNTER_BITS-1:0];
        end
    end

    // Beat/column/row counters with stride phases; phases restart on row/image wrap
    always_comb begin
        s_d   = s_q;
        x_d   = x_q;
        y_d   = y_q;
        xph_d = xph_q;
        yph_d = yph_q;
        if (in_xfer) begin
            if (s_q != S_BITS'(BEATS - 1)) begin
                s_d = s_q + S_BITS'(1);
            end else begin
                s_d = '0;
                if (x_q == xend_q) begin
                    x_d   = '0;
                    xph_d = '0;
                    if (y_q == yend_q) begin
                        y_d   = '0;
                        yph_d = '0;
                    end else begin
                        y_d   = y_q + YCOUNTER_BITS'(1);
                        yph_d = (yph_q == ystride_q) ? '0 : yph_q + YCOUNTER_BITS'(1);
                    end
                end else begin
                    x_d   = x_q + XCOUNTER_BITS'(1);
                    xph_d = (xph_q == xstride_q) ? '0 : xph_q + XCOUNTER_BITS'(1);
                end
            end
        end
    end

    // Counter state registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            xph_q <= '0;
            yph_q <= '0;
        end else begin
            s_q   <= s_d;
            x_q   <= x_d;
            y_q   <= y_d;
            xph_q <= xph_d;
            yph_q <= yph_d;
        end
    end

    // Output valid: set by a kept beat, cleared by a handshake with nothing new
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            tvalid_q <= 1'b0;
        end else if (in_xfer && keep) begin
            tvalid_q <= 1'b1;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    // Output data: only loaded by a kept beat, so it holds during a stall
    always_ff @(posedge ap_clk) begin
        if (in_xfer && keep) begin
            tdata_q <= s_axis_tdata;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_fmdownsample_axi.sv
// Directed bench for fmdownsample_axi: 10x7 image, 2 beats per pixel,
// input beat i carries data i (mod 256).
module tb_fmdownsample_axi;

    localparam int SB = 8;

    logic          clk;
    logic          rst;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [2:0]    awaddr, araddr;
    logic [31:0]   wdata, rdata;
    logic [1:0]    bresp, rresp;
    logic          s_tready, s_tvalid, m_tready, m_tvalid;
    logic [SB-1:0] s_tdata, m_tdata;

    int n_vec = 0;
    int n_err = 0;
    int stab_err;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    fmdownsample_axi #(
        .XCOUNTER_BITS   (8),
        .YCOUNTER_BITS   (8),
        .NUM_CHANNELS    (4),
        .SIMD            (2),
        .ELEM_BITS       (4),
        .INIT_XEND       (9),
        .INIT_YEND       (6),
        .INIT_XSTRIDE_M1 (1),
        .INIT_YSTRIDE_M1 (1)
    ) dut (
        .ap_clk            (clk),
        .ap_rst            (rst),
        .s_axilite_AWVALID (awvalid),
        .s_axilite_AWREADY (awready),
        .s_axilite_AWADDR  (awaddr),
        .s_axilite_WVALID  (wvalid),
        .s_axilite_WREADY  (wready),
        .s_axilite_WDATA   (wdata),
        .s_axilite_WSTRB   (4'hf),
        .s_axilite_BVALID  (bvalid),
        .s_axilite_BREADY  (bready),
        .s_axilite_BRESP   (bresp),
        .s_axilite_ARVALID (arvalid),
        .s_axilite_ARREADY (arready),
        .s_axilite_ARADDR  (araddr),
        .s_axilite_RVALID  (rvalid),
        .s_axilite_RREADY  (rready),
        .s_axilite_RDATA   (rdata),
        .s_axilite_RRESP   (rresp),
        .s_axis_tready     (s_tready),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tdata      (s_tdata),
        .m_axis_tready     (m_tready),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tdata      (m_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pixel (x,y) kept when x%(xs+1)==0 and y%(ys+1)==0
    task automatic model_image(input int base, input int xe, input int ye, input int xs, input int ys);
        int x;
        int y;
        for (int p = 0; p < (xe + 1) * (ye + 1); p++) begin
            x = p % (xe + 1);
            y = p / (xe + 1);
            if ((x % (xs + 1) == 0) && (y % (ys + 1) == 0)) begin
                exp_q.push_back(8'(base + 2 * p));
                exp_q.push_back(8'(base + 2 * p + 1));
            end
        end
    endtask

    // Drive n input beats (data base+k), random sink readiness, collect outputs
    task automatic stream(input int n, input int base, input int ready_pct, input bit drain);
        int sent = 0;
        int cyc = 0;
        bit prev_stall = 0;
        logic [7:0] prev_d = '0;
        @(posedge clk); #1;
        s_tvalid = (n > 0);
        s_tdata  = 8'(base);
        m_tready = ($urandom_range(0, 99) < ready_pct);
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d)) stab_err++;
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            if (m_tvalid && m_tready) got.push_back(m_tdata);
            if (s_tvalid && s_tready) sent++;
            if (sent == n && !s_tvalid && (!drain || !m_tvalid)) break;
            if (cyc > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_timeout sent=%0d required=%0d", sent, n);
                break;
            end
            @(posedge clk); #1;
            s_tvalid = (sent < n);
            s_tdata  = 8'(base + sent);
            m_tready = ($urandom_range(0, 99) < ready_pct);
        end
        s_tvalid = 1'b0;
        $display("stream base=%0d beats=%0d ready=%0d%% outputs_so_far=%0d", base, n, ready_pct, got.size());
    endtask

    task automatic axil_write(input logic [2:0] a, input logic [31:0] d);
        int t;
        bit tmo = 0;
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = a;
        t = 0; @(negedge clk);
        while (!awready && t < 20) begin @(negedge clk); t++; end
        tmo |= (t >= 20);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; wdata = d;
        t = 0; @(negedge clk);
        while (!wready && t < 20) begin @(negedge clk); t++; end
        tmo |= (t >= 20);
        @(posedge clk); #1;
        wvalid = 1'b0; bready = 1'b1;
        t = 0; @(negedge clk);
        while (!bvalid && t < 20) begin @(negedge clk); t++; end
        tmo |= (t >= 20);
        @(posedge clk); #1;
        bready = 1'b0;
        if (tmo) begin
            n_vec++;
            n_err++;
            $display("FAIL axil_write_timeout addr=%0d", a);
        end
        $display("axil write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic axil_read(input logic [2:0] a, output logic [31:0] d);
        int t;
        bit tmo = 0;
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a;
        t = 0; @(negedge clk);
        while (!arready && t < 20) begin @(negedge clk); t++; end
        tmo |= (t >= 20);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        t = 0; @(negedge clk);
        while (!rvalid && t < 20) begin @(negedge clk); t++; end
        tmo |= (t >= 20);
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
        if (tmo) begin
            n_vec++;
            n_err++;
            $display("FAIL axil_read_timeout addr=%0d", a);
        end
        $display("axil read  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int exp_rb[6] = '{9, 1, 0, 0, 6, 1};
        @(negedge clk);
        n_vec++;
        if ({m_tvalid, bvalid, rvalid, wready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_valids got=%b required=0000", {m_tvalid, bvalid, rvalid, wready});
        end
        n_vec++;
        if ({awready, arready, s_tready} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_readies got=%b required=111", {awready, arready, s_tready});
        end
        n_vec++;
        if ({bresp, rresp} !== 4'b0000) begin
            n_err++;
            $display("FAIL resp_okay got=%b required=0000", {bresp, rresp});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < 6; a++) begin
            axil_read(3'(a), rd);
            n_vec++;
            if (rd !== 32'(exp_rb[a])) begin
                n_err++;
                $display("FAIL init_readback addr=%0d got=%0d required=%0d", a, rd, exp_rb[a]);
            end
        end
    endtask

    task automatic test_stride2();
        int bad = -1;
        logic [7:0] hand[6] = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h88, 8'h89};
        int hidx[6] = '{0, 1, 2, 3, 38, 39};
        got.delete(); exp_q.delete();
        model_image(0, 9, 6, 1, 1);
        stream(140, 0, 100, 1);
        n_vec++;
        if (got.size() !== 40) begin
            n_err++;
            $display("FAIL stride2_count got=%0d required=40", got.size());
        end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (hidx[k] >= got.size() || got[hidx[k]] !== hand[k]) begin
                n_err++;
                $display("FAIL stride2_beat idx=%0d got=0x%02h required=0x%02h", hidx[k],
                         (hidx[k] < got.size()) ? got[hidx[k]] : 8'h00, hand[k]);
            end
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL stride2_seq first_bad_idx=%0d got_len=%0d required=0x%02h", bad, got.size(), exp_q[bad]);
        end
    endtask

    task automatic test_stall();
        int bad = -1;
        got.delete(); exp_q.delete();
        stab_err = 0;
        model_image(0, 9, 6, 1, 1);
        stream(140, 0, 25, 1);
        n_vec++;
        if (got.size() !== 40) begin
            n_err++;
            $display("FAIL stall_count got=%0d required=40", got.size());
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL stall_seq first_bad_idx=%0d got_len=%0d required=0x%02h", bad, got.size(), exp_q[bad]);
        end
        n_vec++;
        if (stab_err !== 0) begin
            n_err++;
            $display("FAIL stall_stability violations=%0d required=0", stab_err);
        end
    endtask

    task automatic test_uneven();
        int bad = -1;
        axil_write(3'd1, 32'd2);
        repeat (2) @(posedge clk);
        got.delete(); exp_q.delete();
        model_image(0, 9, 6, 2, 1);
        stream(140, 0, 100, 1);
        n_vec++;
        if (got.size() !== 32) begin
            n_err++;
            $display("FAIL uneven_count got=%0d required=32", got.size());
        end
        // x=0,3,6,9 in row 0 is 8 beats; row 2 starts at pixel 20 -> beat 0x28
        n_vec++;
        if (got.size() < 9 || got[6] !== 8'h12 || got[8] !== 8'h28) begin
            n_err++;
            $display("FAIL uneven_restart got=0x%02h,0x%02h required=0x12,0x28",
                     (got.size() > 6) ? got[6] : 8'h00, (got.size() > 8) ? got[8] : 8'h00);
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL uneven_seq first_bad_idx=%0d got_len=%0d required=0x%02h", bad, got.size(), exp_q[bad]);
        end
    endtask

    task automatic test_passthrough();
        int bad = -1;
        axil_write(3'd1, 32'd0);
        axil_write(3'd5, 32'd0);
        repeat (2) @(posedge clk);
        got.delete(); exp_q.delete();
        for (int i = 0; i < 280; i++) exp_q.push_back(8'(i));
        stream(280, 0, 100, 1);
        n_vec++;
        if (got.size() !== 280) begin
            n_err++;
            $display("FAIL pass_count got=%0d required=280", got.size());
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL pass_seq first_bad_idx=%0d got_len=%0d required=0x%02h", bad, got.size(), exp_q[bad]);
        end
    endtask

    task automatic test_midimage();
        int bad = -1;
        got.delete(); exp_q.delete();
        model_image(0, 9, 6, 0, 0);
        model_image(140, 9, 6, 1, 0);
        stream(50, 0, 100, 0);
        axil_write(3'd1, 32'd1);
        stream(90, 50, 100, 1);
        repeat (3) @(posedge clk);
        stream(140, 140, 100, 1);
        n_vec++;
        if (got.size() !== 210) begin
            n_err++;
            $display("FAIL midimage_count got=%0d required=210", got.size());
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL midimage_seq first_bad_idx=%0d got_len=%0d required=0x%02h", bad, got.size(), exp_q[bad]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int exp_rb[6] = '{9, 1, 0, 0, 6, 1};
        int bad = -1;
        // Config now XStrideM1=1, YStrideM1=0: pixel 14 (beats 28,29) is kept
        got.delete();
        stream(30, 0, 100, 0);
        m_tready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'd29) begin
            n_err++;
            $display("FAIL pending_before_reset got=%b/0x%02h required=1/0x1d", m_tvalid, m_tdata);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL tvalid_in_reset got=%b required=0", m_tvalid);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (m_tvalid !== 1'b0 || awready !== 1'b1) begin
            n_err++;
            $display("FAIL held_reset got=%b%b required=01", m_tvalid, awready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < 6; a++) begin
            axil_read(3'(a), rd);
            n_vec++;
            if (rd !== 32'(exp_rb[a])) begin
                n_err++;
                $display("FAIL post_reset_readback addr=%0d got=%0d required=%0d", a, rd, exp_rb[a]);
            end
        end
        got.delete(); exp_q.delete();
        model_image(0, 9, 6, 1, 1);
        stream(140, 0, 100, 1);
        n_vec++;
        if (got.size() !== 40) begin
            n_err++;
            $display("FAIL post_reset_count got=%0d required=40", got.size());
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
        n_vec++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL post_reset_seq first_bad_idx=%0d got_len=%0d required=0x%02h", bad, got.size(), exp_q[bad]);
        end
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        stab_err = 0;
        repeat (3) @(posedge clk);
        test_reset();
        test_stride2();
        test_stall();
        test_uneven();
        test_passthrough();
        test_midimage();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
